// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit. One shift-add (MULT) or restoring-subtract
// (DIV) step per clock on unsigned magnitudes, followed by one sign-fix cycle.
// The result is held in hi/lo until the next operation completes.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      request pulse, sampled only while idle
//   op_div     0 = multiply, 1 = divide (sampled with start)
//   op_signed  1 = two's-complement operands (sampled with start)
//   a_in       multiplicand / dividend
//   b_in       multiplier / divisor
//   hi         MULT: upper product half, DIV: remainder
//   lo         MULT: lower product half, DIV: quotient
//   busy       operation in progress
//   done       one-cycle completion pulse
//   div_zero   divide by zero flagged with done, cleared by the next accepted start
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    // control strobes from the FSM
    logic accept;
    logic accept_dz;
    logic step;
    logic fix;

    // operation context
    logic             is_div;
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [CW-1:0]    cnt;

    // multiply accumulator: upper half sums, lower half holds remaining multiplier bits
    logic [2*WIDTH-1:0] prod;
    // divide state: remainder and dividend/quotient shift register
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_shift;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH:0]     quo_shift;

    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        accept_dz  = 1'b0;
        step       = 1'b0;
        fix        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_div && (b_in == '0)) begin
                        accept_dz  = 1'b1;
                        state_next = DONE;
                    end else begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                fix        = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Iteration step datapath
    // ------------------------------------------------------------------
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : '0);
        // carry of the add lands in the top bit after the right shift
        mul_shift = {mul_sum, prod[WIDTH-1:0]};
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_fits  = (div_shift >= {1'b0, mag_b});
        quo_shift = {quo, div_fits};
    end

    // Sign correction: the remainder follows the dividend's sign.
    always_comb begin
        prod_fixed = (is_signed && (sign_a ^ sign_b)) ? -prod : prod;
        quo_fixed  = (is_signed && (sign_a ^ sign_b)) ? -quo  : quo;
        rem_fixed  = (is_signed && sign_a)            ? -rem  : rem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            cnt       <= '0;
            prod      <= '0;
            rem       <= '0;
            quo       <= '0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
        end else begin
            if (accept) begin
                is_div    <= op_div;
                is_signed <= op_signed;
                sign_a    <= op_signed & a_in[WIDTH-1];
                sign_b    <= op_signed & b_in[WIDTH-1];
                mag_a     <= magnitude(a_in, op_signed);
                mag_b     <= magnitude(b_in, op_signed);
                cnt       <= '0;
                prod      <= {{WIDTH{1'b0}}, magnitude(b_in, op_signed)};
                rem       <= '0;
                quo       <= magnitude(a_in, op_signed);
                div_zero  <= 1'b0;
            end

            if (accept_dz) begin
                div_zero <= 1'b1;
            end

            if (step) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    // remainder stays below the divisor, so its top bit is always 0
                    rem <= div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    quo <= quo_shift[WIDTH-1:0];
                end else begin
                    prod <= mul_shift[2*WIDTH:1];
                end
            end

            if (fix) begin
                if (is_div) begin
                    hi <= rem_fixed;
                    lo <= quo_fixed;
                end else begin
                    hi <= prod_fixed[2*WIDTH-1:WIDTH];
                    lo <= prod_fixed[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op_div;
    logic        op_signed;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_div    (op_div),
        .op_signed (op_signed),
        .a_in      (a_in),
        .b_in      (b_in),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero
    // and the remainder takes the dividend's sign.
    function automatic void model(input logic d, input logic s,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml);
        logic [63:0]        p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        if (!d) begin
            if (s) p = sa * sb;
            else   p = {32'b0, a} * {32'b0, b};
            mh = p[63:32];
            ml = p[31:0];
        end else if (s) begin
            q  = sa / sb;
            r  = sa % sb;
            ml = q[31:0];
            mh = r[31:0];
        end else begin
            ml = a / b;
            mh = a % b;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0001;
            3:       return 32'h0000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issues one operation and waits for done; cyc = cycle of done relative
    // to the accept edge, -1 on timeout. bad_busy flags busy low while waiting.
    task automatic do_op(input logic d, input logic s, input logic [31:0] a,
                         input logic [31:0] b, output int cyc, output logic bad_busy);
        bad_busy = 1'b0;
        @(negedge clk);
        op_div = d; op_signed = s; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = $urandom;
        b_in  = $urandom;
        cyc   = 1;
        @(negedge clk);
        while (!done && cyc < 100) begin
            if (!busy) bad_busy = 1'b1;
            cyc++;
            @(negedge clk);
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op_div = 1'b0; op_signed = 1'b0;
        a_in = '0; b_in = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({hi, lo, busy, done, div_zero} !== {32'h0, 32'h0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, want all 0",
                     hi, lo, busy, done, div_zero);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic        d[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic        s[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] a[5]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] b[5]  = '{32'd5, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'hFFFF_FFFF};
        logic [31:0] eh[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2, 32'd0};
        logic [31:0] el[5] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'hFFFF_FFFD, 32'd14, 32'h8000_0000};
        int   cyc;
        logic bad;
        for (int i = 0; i < 5; i++) begin
            do_op(d[i], s[i], a[i], b[i], cyc, bad);
            vectors++;
            if (cyc != 34) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: done at cycle %0d, want 34", i, cyc);
            end
            vectors++;
            if ({hi, lo, div_zero} !== {eh[i], el[i], 1'b0}) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: hi=%h lo=%h dz=%b, want hi=%h lo=%h dz=0",
                         i, hi, lo, div_zero, eh[i], el[i]);
            end
            vectors++;
            if ({bad, busy} !== 2'b00) begin
                miscompares++;
                $display("FAIL directed_busy[%0d]: low_during_op=%b busy_at_done=%b, want 0 0",
                         i, bad, busy);
            end
        end
    endtask

    task automatic test_random();
        logic        d, s;
        logic [31:0] a, b, eh, el;
        int          cyc;
        logic        bad;
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom);
            s = 1'($urandom);
            a = pick();
            b = pick();
            if (d && b == 32'h0) b = 32'h0000_0003;
            model(d, s, a, b, eh, el);
            do_op(d, s, a, b, cyc, bad);
            vectors++;
            if (cyc != 34 || {hi, lo, div_zero} !== {eh, el, 1'b0}) begin
                miscompares++;
                $display("FAIL random[%0d] op_div=%b signed=%b a=%h b=%h: cyc=%0d hi=%h lo=%h dz=%b, want cyc=34 hi=%h lo=%h dz=0",
                         i, d, s, a, b, cyc, hi, lo, div_zero, eh, el);
            end
        end
    endtask

    task automatic test_div_zero();
        int   cyc;
        logic bad;
        do_op(1'b0, 1'b0, 32'd20, 32'hE666_6669, cyc, bad);
        vectors++;
        if ({hi, lo} !== {32'h12, 32'h34}) begin
            miscompares++;
            $display("FAIL dz_prior_mult: hi=%h lo=%h, want hi=00000012 lo=00000034", hi, lo);
        end
        do_op(1'b1, 1'($urandom), $urandom, 32'h0, cyc, bad);
        vectors++;
        if (cyc != 1) begin
            miscompares++;
            $display("FAIL dz_latency: done at cycle %0d, want 1", cyc);
        end
        vectors++;
        if ({hi, lo, div_zero, busy} !== {32'h12, 32'h34, 2'b10}) begin
            miscompares++;
            $display("FAIL dz_result: hi=%h lo=%h dz=%b busy=%b, want hi=00000012 lo=00000034 dz=1 busy=0",
                     hi, lo, div_zero, busy);
        end
        @(negedge clk);
        vectors++;
        if ({done, div_zero} !== 2'b01) begin
            miscompares++;
            $display("FAIL dz_hold: done=%b dz=%b, want done=0 dz=1", done, div_zero);
        end
        do_op(1'b1, 1'b0, 32'd9, 32'd4, cyc, bad);
        vectors++;
        if ({hi, lo, div_zero} !== {32'd1, 32'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL dz_cleared: hi=%h lo=%h dz=%b, want hi=1 lo=2 dz=0", hi, lo, div_zero);
        end
    endtask

    task automatic test_start_in_done();
        int          cyc;
        logic        bad;
        logic [31:0] sh, sl;
        do_op(1'b0, 1'b0, 32'd6, 32'd7, cyc, bad);
        sh = hi;
        sl = lo;
        // start raised during the DONE cycle must be ignored
        op_div = 1'b0; op_signed = 1'b0; a_in = 32'd3; b_in = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL start_in_done: busy=%b done=%b, want 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if ({hi, lo} !== {sh, sl} || {sh, sl} !== {32'd0, 32'd42}) begin
            miscompares++;
            $display("FAIL result_hold: hi=%h lo=%h, want hi=0 lo=0000002a", hi, lo);
        end
    endtask

    task automatic test_robustness();
        logic [31:0] eh, el;
        int          cyc;
        logic        bad;
        logic        saw_done;
        model(1'b0, 1'b1, 32'hFEDC_BA98, 32'h0123_4567, eh, el);
        @(negedge clk);
        op_div = 1'b0; op_signed = 1'b1; a_in = 32'hFEDC_BA98; b_in = 32'h0123_4567; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!done && cyc < 100) begin
            if (cyc == 10) begin
                start = 1'b1; op_div = 1'b1; op_signed = 1'b0; a_in = 32'd55; b_in = 32'd0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if (cyc != 34 || {hi, lo, div_zero} !== {eh, el, 1'b0}) begin
            miscompares++;
            $display("FAIL start_while_busy: cyc=%0d hi=%h lo=%h dz=%b, want cyc=34 hi=%h lo=%h dz=0",
                     cyc, hi, lo, div_zero, eh, el);
        end

        // second MULT aborted by reset at cycle 20
        @(negedge clk);
        op_div = 1'b0; op_signed = 1'b0; a_in = 32'd1000; b_in = 32'd1000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if ({busy, done, hi, lo} !== {2'b00, 32'h0, 32'h0}) begin
            miscompares++;
            $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_done: done pulse seen=%b, want 0", saw_done);
        end

        do_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7, cyc, bad);
        vectors++;
        if (cyc != 34 || {hi, lo} !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
            miscompares++;
            $display("FAIL after_reset_op: cyc=%0d hi=%h lo=%h, want cyc=34 hi=fffffffe lo=fffffff2",
                     cyc, hi, lo);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_div_zero();
        test_start_in_done();
        test_robustness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
